param_calc: RTL and testbench

//  Parametrised WIDTH-bit go/done calculator; next generation of the 4-bit small calculator.

---
 rtl/param_calc_pkg.sv | 19 +
 rtl/param_calc_dp.sv | 113 +++++++++++
 rtl/param_calc.sv | 93 +++++++++
 tb/tb_param_calc.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/param_calc_pkg.sv
// Shared opcode values and FSM state encoding for the param_calc calculator.
package param_calc_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_DIV = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/param_calc_dp.sv
// Datapath: operand/shift registers, single-cycle ALU, shift-add MUL and restoring DIV steps,
// and the registered result/flag outputs written only on the finish strobe.
module param_calc_dp
    import param_calc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             finish,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             b_zero,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             flag
);

    logic [WIDTH-1:0] a_r, b_r, hi_r, lo_r;
    logic [WIDTH-1:0] hi_n, lo_n, res_lo, res_hi;
    logic             res_flag;
    logic [WIDTH:0]   sum, diff, mul_add, div_sh, div_sub;
    logic             div_ge;

    assign b_zero  = (b_r == '0);
    assign sum     = {1'b0, a_r} + {1'b0, b_r};
    assign diff    = {1'b0, a_r} - {1'b0, b_r};

    // lo holds A in both iterative ops: for MUL it is the shifting multiplier
    // (product is symmetric), for DIV it is the dividend shifting out into hi.
    assign mul_add = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : '0);
    assign div_sh  = {hi_r, lo_r[WIDTH-1]};
    assign div_sub = div_sh - {1'b0, b_r};
    assign div_ge  = ~div_sub[WIDTH];

    always_comb begin
        hi_n = hi_r;
        lo_n = lo_r;
        if (op == OP_MUL) begin
            hi_n = mul_add[WIDTH:1];
            lo_n = {mul_add[0], lo_r[WIDTH-1:1]};
        end else if (op == OP_DIV) begin
            hi_n = div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0];
            lo_n = {lo_r[WIDTH-2:0], div_ge};
        end
    end

    always_comb begin
        res_lo   = '0;
        res_hi   = '0;
        res_flag = 1'b0;
        case (op)
            OP_ADD: begin
                res_lo   = sum[WIDTH-1:0];
                res_flag = sum[WIDTH];
            end
            OP_SUB: begin
                res_lo   = diff[WIDTH-1:0];
                res_flag = diff[WIDTH];
            end
            OP_AND: res_lo = a_r & b_r;
            OP_OR:  res_lo = a_r | b_r;
            OP_XOR: res_lo = a_r ^ b_r;
            OP_MUL: begin
                res_lo   = lo_n;
                res_hi   = hi_n;
                res_flag = (hi_n != '0);
            end
            OP_DIV: begin
                if (b_zero) begin
                    res_lo   = '1;
                    res_hi   = a_r;
                    res_flag = 1'b1;
                end else begin
                    res_lo = lo_n;
                    res_hi = hi_n;
                end
            end
            default: res_flag = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            out    <= '0;
            out_hi <= '0;
            flag   <= 1'b0;
        end else begin
            if (load) begin
                a_r  <= in1;
                b_r  <= in2;
                hi_r <= '0;
                lo_r <= in1;
            end else if (step) begin
                hi_r <= hi_n;
                lo_r <= lo_n;
            end
            if (finish) begin
                out    <= res_lo;
                out_hi <= res_hi;
                flag   <= res_flag;
            end
        end
    end

endmodule

// File: rtl/param_calc.sv
// Top level: IDLE/EXEC/DONE control FSM with opcode and iteration counter, wrapping the datapath.
module param_calc
    import param_calc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             flag
);

    localparam int CNTW = $clog2(WIDTH + 1);

    state_t          state, state_n;
    logic [2:0]      op_r;
    logic [CNTW-1:0] cnt;
    logic            load, step, finish, b_zero, multi;

    assign busy  = (state != S_IDLE);
    assign done  = (state == S_DONE);
    assign multi = (op_r == OP_MUL) || ((op_r == OP_DIV) && !b_zero);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            op_r  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            if (load) begin
                op_r <= op;
                cnt  <= CNTW'(WIDTH);
            end else if (step) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // The last iteration and the result write share one edge, so partial
    // products/quotients never reach the output registers.
    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state)
            S_IDLE: begin
                if (go) begin
                    load    = 1'b1;
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                if (multi) begin
                    step = 1'b1;
                    if (cnt == CNTW'(1)) begin
                        finish  = 1'b1;
                        state_n = S_DONE;
                    end
                end else begin
                    finish  = 1'b1;
                    state_n = S_DONE;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    param_calc_dp #(.WIDTH(WIDTH)) u_dp (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .finish (finish),
        .op     (op_r),
        .in1    (in1),
        .in2    (in2),
        .b_zero (b_zero),
        .out    (out),
        .out_hi (out_hi),
        .flag   (flag)
    );

endmodule

// File: tb/tb_param_calc.sv
// Directed bench for param_calc: a WIDTH=4 and a WIDTH=8 instance sharing clock and reset.
module tb_param_calc;
    import param_calc_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       go  = 1'b0;
    logic       sel8 = 1'b0;
    logic [7:0] in1 = '0;
    logic [7:0] in2 = '0;
    logic [2:0] op  = '0;

    logic       busy4, done4, flag4, busy8, done8, flag8;
    logic [3:0] out4, out_hi4;
    logic [7:0] out8, out_hi8;
    logic       go4, go8;

    int checks   = 0;
    int failures = 0;

    assign go4 = go & ~sel8;
    assign go8 = go & sel8;

    wire [7:0] m_out    = sel8 ? out8    : {4'b0, out4};
    wire [7:0] m_out_hi = sel8 ? out_hi8 : {4'b0, out_hi4};
    wire       m_flag   = sel8 ? flag8   : flag4;
    wire       m_busy   = sel8 ? busy8   : busy4;
    wire       m_done   = sel8 ? done8   : done4;

    param_calc #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .go(go4), .in1(in1[3:0]), .in2(in2[3:0]), .op(op),
        .busy(busy4), .done(done4), .out(out4), .out_hi(out_hi4), .flag(flag4)
    );

    param_calc #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .go(go8), .in1(in1), .in2(in2), .op(op),
        .busy(busy8), .done(done8), .out(out8), .out_hi(out_hi8), .flag(flag8)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        for (int s = 0; s < 2; s++) begin
            sel8 = (s == 1);
            #0;
            checks++;
            if ({m_out, m_out_hi, m_flag, m_busy, m_done} !== 19'd0) begin
                failures++;
                $display("FAIL reset_w%0d out=%0d out_hi=%0d flag=%b busy=%b done=%b required all 0",
                         s ? 8 : 4, m_out, m_out_hi, m_flag, m_busy, m_done);
            end
        end
        sel8 = 1'b0;
        rst  = 1'b0;
        tick();
    endtask

    // Issues one op, scrambles the inputs after acceptance, then checks latency, results and the done pulse width.
    task automatic run_op(input logic wide, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] o, input int exp_lat, input logic [7:0] exp_out,
                          input logic [7:0] exp_hi, input logic exp_flag, input string name);
        int lat;
        sel8 = wide;
        in1 = a; in2 = b; op = o; go = 1'b1;
        tick();
        go = 1'b0; in1 = ~a; in2 = ~b; op = ~o;
        checks++;
        if (m_busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_busy busy=%b required 1", name, m_busy);
        end
        lat = 0;
        while (m_done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== exp_lat) begin
            failures++;
            $display("FAIL %s_latency cycles=%0d required %0d", name, lat, exp_lat);
        end
        checks++;
        if (m_out !== exp_out || m_out_hi !== exp_hi || m_flag !== exp_flag) begin
            failures++;
            $display("FAIL %s_result out=%0d out_hi=%0d flag=%b required out=%0d out_hi=%0d flag=%b",
                     name, m_out, m_out_hi, m_flag, exp_out, exp_hi, exp_flag);
        end
        tick();
        checks++;
        if (m_done !== 1'b0 || m_busy !== 1'b0 || m_out !== exp_out) begin
            failures++;
            $display("FAIL %s_after done=%b busy=%b out=%0d required done=0 busy=0 out=%0d",
                     name, m_done, m_busy, m_out, exp_out);
        end
    endtask

    task automatic test_alu();
        run_op(1'b0, 8'd9,  8'd8,  OP_ADD, 1, 8'd1,  8'd0, 1'b1, "add_9_8");
        run_op(1'b0, 8'd3,  8'd5,  OP_SUB, 1, 8'd14, 8'd0, 1'b1, "sub_3_5");
        run_op(1'b0, 8'd5,  8'd3,  OP_SUB, 1, 8'd2,  8'd0, 1'b0, "sub_5_3");
        run_op(1'b0, 8'd12, 8'd10, OP_AND, 1, 8'd8,  8'd0, 1'b0, "and");
        run_op(1'b0, 8'd12, 8'd3,  OP_OR,  1, 8'd15, 8'd0, 1'b0, "or");
        run_op(1'b0, 8'd12, 8'd10, OP_XOR, 1, 8'd6,  8'd0, 1'b0, "xor");
        run_op(1'b0, 8'd7,  8'd2,  OP_ILL, 1, 8'd0,  8'd0, 1'b1, "ill_w4");
    endtask

    task automatic test_mul_div();
        run_op(1'b0, 8'd7,  8'd6, OP_MUL, 4, 8'd10, 8'd2,  1'b1, "mul_7_6");
        run_op(1'b0, 8'd3,  8'd5, OP_MUL, 4, 8'd15, 8'd0,  1'b0, "mul_3_5");
        run_op(1'b0, 8'd13, 8'd4, OP_DIV, 4, 8'd3,  8'd1,  1'b0, "div_13_4");
        run_op(1'b0, 8'd13, 8'd0, OP_DIV, 1, 8'd15, 8'd13, 1'b1, "div_13_0");
        run_op(1'b0, 8'd15, 8'd1, OP_DIV, 4, 8'd15, 8'd0,  1'b0, "div_15_1");
    endtask

    task automatic test_abort();
        run_op(1'b0, 8'd9, 8'd8, OP_ADD, 1, 8'd1, 8'd0, 1'b1, "pre_abort");
        sel8 = 1'b0;
        in1 = 8'd7; in2 = 8'd6; op = OP_MUL; go = 1'b1;
        tick();
        go = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({out4, out_hi4, flag4, busy4, done4} !== 11'd0) begin
            failures++;
            $display("FAIL abort_clear out=%0d out_hi=%0d flag=%b busy=%b done=%b required all 0",
                     out4, out_hi4, flag4, busy4, done4);
        end
        #2;
        rst = 1'b0;
        tick();
        run_op(1'b0, 8'd2, 8'd2, OP_ADD, 1, 8'd4, 8'd0, 1'b0, "add_after_abort");
    endtask

    task automatic test_back_to_back();
        logic exp_done;
        sel8 = 1'b0;
        in1 = 8'd1; in2 = 8'd2; op = OP_ADD; go = 1'b1;
        tick();
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_done = (k % 3 == 1);
            checks++;
            if (done4 !== exp_done || (exp_done && out4 !== 4'd3)) begin
                failures++;
                $display("FAIL b2b_cycle%0d done=%b out=%0d required done=%b out=3",
                         k, done4, out4, exp_done);
            end
        end
        go = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_go_ignored();
        int lat;
        sel8 = 1'b0;
        in1 = 8'd3; in2 = 8'd5; op = OP_MUL; go = 1'b1;
        tick();
        go = 1'b0; in1 = 8'd9; in2 = 8'd8; op = OP_ADD;
        tick();
        go = 1'b1;
        tick();
        go = 1'b0;
        lat = 2;
        while (done4 !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== 4 || out4 !== 4'd15 || out_hi4 !== 4'd0 || flag4 !== 1'b0) begin
            failures++;
            $display("FAIL go_ignored cycles=%0d out=%0d out_hi=%0d flag=%b required 4 15 0 0",
                     lat, out4, out_hi4, flag4);
        end
        repeat (2) tick();
        checks++;
        if (busy4 !== 1'b0) begin
            failures++;
            $display("FAIL go_ignored_idle busy=%b required 0", busy4);
        end
    endtask

    task automatic test_width8();
        run_op(1'b1, 8'd255, 8'd255, OP_MUL, 8, 8'd1,  8'd254, 1'b1, "w8_mul_255_255");
        run_op(1'b1, 8'd200, 8'd7,   OP_DIV, 8, 8'd28, 8'd4,   1'b0, "w8_div_200_7");
        run_op(1'b1, 8'd200, 8'd100, OP_ADD, 1, 8'd44, 8'd0,   1'b1, "w8_add");
        run_op(1'b1, 8'd17,  8'd33,  OP_ILL, 1, 8'd0,  8'd0,   1'b1, "w8_ill");
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mul_div();
        test_abort();
        test_back_to_back();
        test_go_ignored();
        test_width8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
